s_mem_reader: RTL and testbench



---
 rtl/s_mem_pkg.sv | 21 ++
 rtl/s_mem_reader.sv | 169 ++++++++++++++++
 tb/tb_s_mem_reader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/s_mem_pkg.sv
// Shared types and sizing for the S-memory initialiser and reader.
package s_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } rd_state_t;

  localparam int S_DEPTH  = 256;
  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;
  localparam int S_RD_LAT = 1;

  // Width of a counter that must reach lat-1; never narrower than one bit.
  function automatic int lat_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/s_mem_reader.sv
// Streams s_mem[0..DEPTH-1] out on a valid/ready port, started by the en/rdy handshake.
// Optional READER_CHECK_EN build adds a sticky err/err_addr self-check (rddata vs. address).
module s_mem_reader
  import s_mem_pkg::*;
#(
  parameter int DEPTH  = S_DEPTH,
  parameter int ADDR_W = S_ADDR_W,
  parameter int DATA_W = S_DATA_W,
  parameter int RD_LAT = S_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  output logic              wren,
  input  logic [DATA_W-1:0] rddata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef READER_CHECK_EN
  ,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
`endif
);

  localparam int LAT_W = lat_width(RD_LAT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [LAT_W-1:0]  LAT_END   = LAT_W'(RD_LAT - 1);

  rd_state_t         state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              start_s;
  logic              capture_s;

  // Next-state and output-register logic for the read walk.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lat_d     = lat_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    start_s   = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          start_s = 1'b1;
          addr_d  = {ADDR_W{1'b0}};
          lat_d   = {LAT_W{1'b0}};
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_END) begin
          capture_s = 1'b1;
          data_d    = rddata;
          valid_d   = 1'b1;
          last_d    = (addr_q == LAST_ADDR);
          state_d   = HOLD;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            last_d  = 1'b0;
            addr_d  = {ADDR_W{1'b0}};
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            lat_d   = {LAT_W{1'b0}};
            state_d = READ;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = {ADDR_W{1'b0}};
        lat_d   = {LAT_W{1'b0}};
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
    // rdy is registered so it tracks the state being entered, not the current one.
    rdy_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      addr_q  <= {ADDR_W{1'b0}};
      lat_q   <= {LAT_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign rdy       = rdy_q;
  assign addr      = addr_q;
  assign wren      = 1'b0;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

`ifdef READER_CHECK_EN
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  // Records only the first word whose content differs from its own address.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (start_s) begin
      err_d      = 1'b0;
      err_addr_d = {ADDR_W{1'b0}};
    end else if (capture_s && !err_q && (rddata != DATA_W'(addr_q))) begin
      err_d      = 1'b1;
      err_addr_d = addr_q;
    end else begin
      err_d      = err_q;
      err_addr_d = err_addr_q;
    end
  end

  // Sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_addr_q <= {ADDR_W{1'b0}};
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_s_mem_reader.sv
// Bench for s_mem_reader: synchronous RAM model, stream scoreboard and directed scenarios.
module tb_s_mem_reader;
  import s_mem_pkg::*;

  localparam int DEPTH  = 256;
  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;
  localparam int BUDGET = 6000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          rdy;
  logic [AW-1:0] addr;
  logic          wren;
  logic [DW-1:0] rddata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
`ifdef READER_CHECK_EN
  logic          err;
  logic [AW-1:0] err_addr;
`endif

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] mem [DEPTH];
  int  exp_idx   = 0;
  int  acc_total = 0;
  int  last_total = 0;
  bit  rand_ready = 1'b0;
  bit  ready_const = 1'b1;

  s_mem_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .addr      (addr),
    .wren      (wren),
    .rddata    (rddata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef READER_CHECK_EN
    ,
    .err       (err),
    .err_addr  (err_addr)
`endif
  );

  always #5 clk = ~clk;

  // s_mem: one-edge read latency.
  always @(posedge clk) rddata <= mem[addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: run k must present mem[k] at index k, last only on DEPTH-1.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_idx = 0;
      end else begin
        check("wren", 32'(wren), 32'h0);
        if (out_valid) begin
          check("out_data", 32'(out_data), 32'(mem[exp_idx]));
          check("out_last", 32'(out_last), 32'(exp_idx == DEPTH - 1));
          check("addr_hold", 32'(addr), 32'(exp_idx));
          if (out_ready) begin
            acc_total++;
            if (exp_idx == DEPTH - 1) begin
              last_total++;
              exp_idx = 0;
            end else begin
              exp_idx++;
            end
          end
        end else begin
          check("out_last_novalid", 32'(out_last), 32'h0);
        end
      end
    end
  end

  // Consumer: either constant or ~30% random ready, changed just after each edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 9) < 3);
      else            out_ready = ready_const;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic pulse_en_measure();
    int n;
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    check("rdy_drop", 32'(rdy), 32'h0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
    check("first_latency", 32'(n), 32'(RD_LAT + 2));
    check("first_word", 32'(out_data), 32'h00);
  endtask

  task automatic wait_last();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) begin
        ok = 1'b1;
        break;
      end
    end
    check("last_seen", 32'(ok), 32'h1);
    check("last_word", 32'(out_data), 32'hFF);
  endtask

  initial begin
    int acc0;
    int last0;
    bit found;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    rst_n = 1'b0;
    en    = 1'b0;

    // 1: reset values, idle with en low
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'h1);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_last", 32'(out_last), 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_rdy", 32'(rdy), 32'h1);
      check("idle_valid", 32'(out_valid), 32'h0);
      check("idle_addr", 32'(addr), 32'h0);
    end

    // 2: full run with out_ready held high
    acc0 = acc_total; last0 = last_total;
    pulse_en_measure();
    wait_last();
    @(negedge clk);
    check("rdy_after_last", 32'(rdy), 32'h1);
    check("valid_after_last", 32'(out_valid), 32'h0);
    check("run2_words", 32'(acc_total - acc0), 32'd256);
    check("run2_lasts", 32'(last_total - last0), 32'd1);

    // 3: random backpressure
    rand_ready = 1'b1;
    acc0 = acc_total; last0 = last_total;
    pulse_en_measure();
    wait_last();
    rand_ready = 1'b0;
    @(negedge clk);
    check("rdy_after_rand", 32'(rdy), 32'h1);
    check("run3_words", 32'(acc_total - acc0), 32'd256);
    check("run3_lasts", 32'(last_total - last0), 32'd1);

    // 4: en held high -> exactly one run, then a new one
    acc0 = acc_total; last0 = last_total;
    @(posedge clk); #1 en = 1'b1;
    wait_last();
    check("run4_words", 32'(acc_total - acc0), 32'd256);
    @(negedge clk);
    check("rdy_between_runs", 32'(rdy), 32'h1);
    @(posedge clk); #1;
    check("rdy_second_run", 32'(rdy), 32'h0);
    en = 1'b0;
    wait_last();
    check("run4_total_words", 32'(acc_total - acc0), 32'd512);
    check("run4_lasts", 32'(last_total - last0), 32'd2);
    @(negedge clk);

    // 5: reset after word 0x40 accepted, then restart from 0x00
    pulse_en_measure();
    found = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_data == 8'h40) begin
        found = 1'b1;
        break;
      end
    end
    check("word40_seen", 32'(found), 32'h1);
    last0 = last_total;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_rdy", 32'(rdy), 32'h1);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_addr", 32'(addr), 32'h0);
    check("midrst_data", 32'(out_data), 32'h0);
    check("midrst_last", 32'(out_last), 32'h0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    check("midrst_no_last", 32'(last_total - last0), 32'h0);
    pulse_en_measure();
    wait_last();
    @(negedge clk);

`ifdef READER_CHECK_EN
    // 6: content self-check records only the first mismatch
    mem[8'h42] = 8'h99;
    mem[8'h80] = 8'h00;
    pulse_en_measure();
    check("err_clear_start", 32'(err), 32'h0);
    wait_last();
    @(negedge clk);
    check("err_set", 32'(err), 32'h1);
    check("err_addr_first", 32'(err_addr), 32'h42);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    check("err_clr_on_en", 32'(err), 32'h0);
    check("err_addr_clr_on_en", 32'(err_addr), 32'h0);
    wait_last();
    @(negedge clk);
    check("err_reset_run", 32'(err), 32'h1);
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
